alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-port arbiter and sequencer that shares one instance of the team's 32-bit ALU core (operands a/b, 4-bit aluc; outputs y, zero, carry, negative, overflow) between two requesters, e.g. the integer pipeline and a multi-cycle helper unit. Requests are accepted with valid/ready handshakes under round-robin priority and executed one at a time. Operands are registered before they reach the ALU, and results are returned through a held response with its own handshake. Illegal opcodes are trapped, and completed operations are counted.

## Interface
- No parameters; the requester count is fixed at 2 and the data width at 32.
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous reset, active-high
- reqN_valid_i  in  1  requester N (N=0,1) presents an operation
- reqN_ready_o  out  1  block accepts requester N this cycle
- reqN_a_i  in  32  operand a of requester N
- reqN_b_i  in  32  operand b of requester N
- reqN_aluc_i  in  4  ALU opcode of requester N; legal range 0000–1101
- rspN_valid_o  out  1  response for requester N is held
- rspN_ready_i  in  1  requester N takes the response
- rsp_y_o  out  32  result, shared by both requesters and qualified by rspN_valid_o
- rsp_flags_o  out  4  {overflow, negative, carry, zero} from the ALU core
- rsp_err_o  out  1  opcode was illegal
- busy_o  out  1  state is not IDLE
- done_count_o  out  16  number of completed response handshakes

## Operation
- State machine:
  - IDLE: arbitrate; accept at most one request.
  - EXEC: the ALU evaluates the registered operands; y, flags and err are captured at the end of the cycle.
  - RESP: hold the response until it is taken.
- Transitions:
  - IDLE→EXEC on an accepted request (reqN_valid_i && reqN_ready_o); otherwise stay in IDLE.
  - EXEC→RESP unconditionally.
  - RESP→IDLE when the owner's rspN_valid_o && rspN_ready_i; otherwise stay in RESP.
- Arbitration (round-robin, 1-bit last_grant):
  - Only one requester valid: it is granted.
  - Both valid: grant the requester not equal to last_grant.
  - last_grant updates to the granted index on acceptance.
- reqN_ready_o = (state==IDLE) && granted(N). It is combinational from the valid inputs; reqN_ready_o is never high in EXEC or RESP.
- On acceptance, latch a, b, aluc and owner index. These registers do not change again until the next acceptance.
- Illegal aluc (1110, 1111):
  - rsp_y_o = 0, rsp_flags_o = 0, rsp_err_o = 1.
  - The ALU outputs are ignored.
- Legal aluc:
  - rsp_y_o and rsp_flags_o equal the ALU core outputs for the latched operands, unmodified.
  - rsp_err_o = 0.
- Response routing:
  - Only the owner's rspN_valid_o asserts; the other stays 0.
  - The rspN_ready_i of the non-owner is ignored.
- done_count_o:
  - Increments by 1 on each response handshake, including errored responses.
  - Wraps 0xFFFF→0x0000.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1 (requester 0 wins the first tie).
  - All valid/ready outputs = 0, rsp_y_o = 0, rsp_flags_o = 0, rsp_err_o = 0.
  - busy_o = 0, done_count_o = 0.
- Latency:
  - Request accepted in cycle T.
  - rspN_valid_o is high from cycle T+2.
  - The earliest response handshake is in cycle T+2.
- Throughput: the back-to-back minimum is 3 cycles per operation. After a handshake in cycle R, the next acceptance is possible in cycle R+1.
- Stability:
  - Response outputs stay constant while in RESP, regardless of request inputs.
  - A requester held off by arbitration keeps its valid asserted; the block does not require this, but the bench checks a stalled request is eventually granted.
- Simultaneous events:
  - Both valid in IDLE: exactly one ready_o is high.
  - A request arriving while in RESP with a handshake in the same cycle is not accepted until the next cycle (IDLE).
- Reset mid-operation (rst_i in EXEC or RESP):
  - Next cycle is IDLE and the in-flight operation is dropped.
  - No response or count increment occurs.
  - rst_i dominates a coincident handshake.

## Test plan
- Reset, then req0 ADDU (aluc 0001) with a=0x00000003, b=0x00000004 -> ready0 high in cycle T; rsp0_valid high at T+2; y=0x00000007, zero=0, err=0; done_count=1 after the handshake.
- Both valid continuously, req0 SUB (0010) 5−5 and req1 OR (0101) 0xF0|0x0F -> grants alternate 0,1,0,1. Req0 responses: y=0, zero=1. Req1 responses: y=0x000000FF. rsp1_valid is never high for a req0 operation.
- req1 with aluc=1111 -> rsp1_valid at T+2; y=0, flags=0, err=1; done_count increments.
- Response backpressure: rsp0_ready low for 5 cycles while req1 valid -> outputs held constant; ready1 stays 0 until the handshake; req1 is accepted the cycle after the handshake.
- rst_i asserted in EXEC, then in RESP -> IDLE next cycle; all valid outputs 0; done_count unchanged; the next tie is granted to req0.
- 65536 ADDU operations with ready held high -> done_count wraps to 0x0000; the spacing between handshakes is 3 cycles throughout.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU core between two requesters.
// Operands are registered at acceptance; the result is held until taken.
module alu_core (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_aluc,
    output logic [31:0] o_y,
    output logic        o_zero,
    output logic        o_carry,
    output logic        o_negative,
    output logic        o_overflow
);
    logic [32:0] w_ext;
    logic [31:0] w_y;
    logic        w_carry;
    logic        w_ovf;

    always_comb begin
        w_ext   = '0;
        w_y     = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (i_aluc)
            4'b0000, 4'b0001: begin
                w_ext   = {1'b0, i_a} + {1'b0, i_b};
                w_y     = w_ext[31:0];
                w_carry = w_ext[32];
                w_ovf   = (i_a[31] == i_b[31]) && (w_y[31] != i_a[31]);
            end
            // carry is the inverted borrow: set when a >= b unsigned
            4'b0010, 4'b0011: begin
                w_ext   = {1'b0, i_a} + {1'b0, ~i_b} + 33'd1;
                w_y     = w_ext[31:0];
                w_carry = w_ext[32];
                w_ovf   = (i_a[31] != i_b[31]) && (w_y[31] != i_a[31]);
            end
            4'b0100: w_y = i_a & i_b;
            4'b0101: w_y = i_a | i_b;
            4'b0110: w_y = i_a ^ i_b;
            4'b0111: w_y = ~(i_a | i_b);
            4'b1000: w_y = {31'd0, $signed(i_a) < $signed(i_b)};
            4'b1001: w_y = {31'd0, i_a < i_b};
            4'b1010: w_y = i_b << i_a[4:0];
            4'b1011: w_y = i_b >> i_a[4:0];
            4'b1100: w_y = $unsigned($signed(i_b) >>> i_a[4:0]);
            4'b1101: w_y = {i_b[15:0], 16'h0000};
            default: w_y = '0;
        endcase
    end

    assign o_y        = w_y;
    assign o_zero     = (w_y == 32'd0);
    assign o_carry    = w_carry;
    assign o_negative = w_y[31];
    assign o_overflow = w_ovf;
endmodule

module alu_share_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    input  logic [3:0]  req0_aluc_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    input  logic [3:0]  req1_aluc_i,
    output logic        rsp0_valid_o,
    input  logic        rsp0_ready_i,
    output logic        rsp1_valid_o,
    input  logic        rsp1_ready_i,
    output logic [31:0] rsp_y_o,
    output logic [3:0]  rsp_flags_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic [15:0] done_count_o
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t      r_state;
    logic        r_last_grant;
    logic        r_owner;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_aluc;
    logic [31:0] r_y;
    logic [3:0]  r_flags;
    logic        r_err;
    logic        r_rsp_v0;
    logic        r_rsp_v1;
    logic [15:0] r_done_count;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_idle;
    logic        w_accept;
    logic        w_hs;
    logic        w_illegal;
    logic [31:0] w_alu_y;
    logic        w_zero;
    logic        w_carry;
    logic        w_neg;
    logic        w_ovf;

    // On a tie the requester that did not win last time is granted
    assign w_grant0  = req0_valid_i && (!req1_valid_i || r_last_grant);
    assign w_grant1  = req1_valid_i && (!req0_valid_i || !r_last_grant);
    assign w_idle    = (r_state == S_IDLE);
    assign w_accept  = w_idle && (req0_valid_i || req1_valid_i);
    assign w_hs      = (r_rsp_v0 && rsp0_ready_i)
                     || (r_rsp_v1 && rsp1_ready_i);
    assign w_illegal = (r_aluc[3:1] == 3'b111);

    alu_core u_alu (
        .i_a        (r_a),
        .i_b        (r_b),
        .i_aluc     (r_aluc),
        .o_y        (w_alu_y),
        .o_zero     (w_zero),
        .o_carry    (w_carry),
        .o_negative (w_neg),
        .o_overflow (w_ovf)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_aluc       <= '0;
            r_y          <= '0;
            r_flags      <= '0;
            r_err        <= 1'b0;
            r_rsp_v0     <= 1'b0;
            r_rsp_v1     <= 1'b0;
            r_done_count <= '0;
        end else begin
            r_done_count <= r_done_count + {15'd0, w_hs};
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_grant1 ? req1_a_i : req0_a_i;
                        r_b          <= w_grant1 ? req1_b_i : req0_b_i;
                        r_aluc       <= w_grant1 ? req1_aluc_i : req0_aluc_i;
                        r_owner      <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_y      <= w_illegal ? 32'd0 : w_alu_y;
                    r_flags  <= w_illegal ? 4'd0
                              : {w_ovf, w_neg, w_carry, w_zero};
                    r_err    <= w_illegal;
                    r_rsp_v0 <= !r_owner;
                    r_rsp_v1 <= r_owner;
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    if (w_hs) begin
                        r_rsp_v0 <= 1'b0;
                        r_rsp_v1 <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req0_ready_o = w_idle && w_grant0;
    assign req1_ready_o = w_idle && w_grant1;
    assign rsp0_valid_o = r_rsp_v0;
    assign rsp1_valid_o = r_rsp_v1;
    assign rsp_y_o      = r_y;
    assign rsp_flags_o  = r_flags;
    assign rsp_err_o    = r_err;
    assign busy_o       = !w_idle;
    assign done_count_o = r_done_count;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized self-checking bench for alu_share_arbiter.
// Expected results come from a plain-arithmetic ALU model.
module tb_alu_share_arbiter;
    logic        clk;
    logic        rst;
    logic        v[2];
    logic [31:0] a[2];
    logic [31:0] b[2];
    logic [3:0]  c[2];
    logic        rr[2];
    logic        rdy[2];
    logic        rspv[2];
    logic [31:0] y;
    logic [3:0]  flags;
    logic        err;
    logic        busy;
    logic [15:0] cnt;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_cnt;
    logic        exp_last;

    alu_share_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (v[0]),
        .req0_ready_o (rdy[0]),
        .req0_a_i     (a[0]),
        .req0_b_i     (b[0]),
        .req0_aluc_i  (c[0]),
        .req1_valid_i (v[1]),
        .req1_ready_o (rdy[1]),
        .req1_a_i     (a[1]),
        .req1_b_i     (b[1]),
        .req1_aluc_i  (c[1]),
        .rsp0_valid_o (rspv[0]),
        .rsp0_ready_i (rr[0]),
        .rsp1_valid_o (rspv[1]),
        .rsp1_ready_i (rr[1]),
        .rsp_y_o      (y),
        .rsp_flags_o  (flags),
        .rsp_err_o    (err),
        .busy_o       (busy),
        .done_count_o (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic [3:0] mc, output logic [31:0] my,
                                  output logic [3:0] mf, output logic me);
        longint sa, sb, s, u;
        logic   cy, ov;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        my = 0; cy = 0; ov = 0; me = 0; s = 0; u = 0;
        case (mc)
            4'd0, 4'd1: begin
                u  = longint'(ma) + longint'(mb);
                my = u[31:0];
                cy = u[32];
                s  = sa + sb;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2, 4'd3: begin
                my = ma - mb;
                cy = (ma >= mb);
                s  = sa - sb;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4: my = ma & mb;
            4'd5: my = ma | mb;
            4'd6: my = ma ^ mb;
            4'd7: my = ~(ma | mb);
            4'd8: my = (sa < sb) ? 32'd1 : 32'd0;
            4'd9: my = (ma < mb) ? 32'd1 : 32'd0;
            4'd10: my = mb << ma[4:0];
            4'd11: my = mb >> ma[4:0];
            4'd12: begin
                s  = sb >>> ma[4:0];
                my = s[31:0];
            end
            4'd13: my = mb * 32'd65536;
            default: begin
                me = 1;
                my = 0;
            end
        endcase
        mf = me ? 4'd0 : {ov, my[31], cy, (my == 32'd0)};
    endfunction

    task automatic drive_idle();
        v[0] = 0; v[1] = 0; rr[0] = 0; rr[1] = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        exp_cnt = 0;
        exp_last = 1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if ({rdy[1], rdy[0]} !== 2'b00) begin failures++; $display("FAIL rst_ready got=%b exp=00", {rdy[1], rdy[0]}); end
        checks++; if ({rspv[1], rspv[0]} !== 2'b00) begin failures++; $display("FAIL rst_rspv got=%b exp=00", {rspv[1], rspv[0]}); end
        checks++; if (y !== 32'd0) begin failures++; $display("FAIL rst_y got=%h exp=0", y); end
        checks++; if (flags !== 4'd0) begin failures++; $display("FAIL rst_flags got=%b exp=0", flags); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL rst_count got=%h exp=0", cnt); end
        v[0] = 1; v[1] = 1;
        #1;
        checks++; if ({rdy[1], rdy[0]} !== 2'b01) begin failures++; $display("FAIL rst_first_tie got=%b exp=01", {rdy[1], rdy[0]}); end
        drive_idle();
    endtask

    task automatic test_ops();
        logic [31:0] ey, ta, tb;
        logic [3:0]  ef, tc;
        logic        ee;
        int          idx;
        for (int k = 0; k < 24; k++) begin
            idx = $urandom_range(0, 1);
            ta = $urandom; tb = $urandom; tc = 4'($urandom_range(0, 15));
            if (k == 0) begin idx = 0; ta = 3; tb = 4; tc = 4'd1; end
            if (k == 1) begin idx = 1; tc = 4'hF; end
            if (k == 2) begin idx = 0; ta = 32'h7FFFFFFF; tb = 1; tc = 4'd0; end
            if (k == 3) begin idx = 1; ta = 32'h80000000; tb = 1; tc = 4'd2; end
            if (k == 4) begin idx = 0; tc = 4'hE; end
            model(ta, tb, tc, ey, ef, ee);
            @(negedge clk);
            a[idx] = ta; b[idx] = tb; c[idx] = tc; v[idx] = 1;
            v[1-idx] = 0; a[1-idx] = $urandom;
            #1;
            checks++; if ({rdy[1], rdy[0]} !== (idx != 0 ? 2'b10 : 2'b01)) begin failures++; $display("FAIL op_ready k=%0d got=%b idx=%0d", k, {rdy[1], rdy[0]}, idx); end
            @(posedge clk);
            exp_last = idx[0];
            @(negedge clk);
            v[0] = 1'($urandom); v[1] = 1'($urandom); a[idx] = $urandom;
            #1;
            checks++; if ({rdy[1], rdy[0]} !== 2'b00) begin failures++; $display("FAIL exec_ready k=%0d got=%b exp=00", k, {rdy[1], rdy[0]}); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL exec_busy k=%0d got=%b exp=1", k, busy); end
            checks++; if ({rspv[1], rspv[0]} !== 2'b00) begin failures++; $display("FAIL exec_rspv k=%0d got=%b exp=00", k, {rspv[1], rspv[0]}); end
            @(negedge clk);
            rr[idx] = 1; rr[1-idx] = 1'($urandom);
            #1;
            checks++; if ({rspv[1], rspv[0]} !== (idx != 0 ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rsp_valid k=%0d got=%b idx=%0d", k, {rspv[1], rspv[0]}, idx); end
            checks++; if (y !== ey) begin failures++; $display("FAIL rsp_y k=%0d aluc=%h got=%h exp=%h", k, tc, y, ey); end
            checks++; if (flags !== ef) begin failures++; $display("FAIL rsp_flags k=%0d aluc=%h got=%b exp=%b", k, tc, flags, ef); end
            checks++; if (err !== ee) begin failures++; $display("FAIL rsp_err k=%0d got=%b exp=%b", k, err, ee); end
            checks++; if ({rdy[1], rdy[0]} !== 2'b00) begin failures++; $display("FAIL resp_ready k=%0d got=%b exp=00", k, {rdy[1], rdy[0]}); end
            if (k == 0) begin
                checks++; if (y !== 32'h7 || flags[0] !== 1'b0) begin failures++; $display("FAIL addu_3p4 got=%h exp=7", y); end
            end
            @(posedge clk);
            exp_cnt++;
            @(negedge clk);
            drive_idle();
            #1;
            checks++; if (cnt !== exp_cnt) begin failures++; $display("FAIL op_count k=%0d got=%h exp=%h", k, cnt, exp_cnt); end
            checks++; if ({rspv[1], rspv[0]} !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL op_done k=%0d rspv=%b busy=%b exp=00,0", k, {rspv[1], rspv[0]}, busy); end
        end
    endtask

    task automatic test_round_robin();
        int   ops = 0;
        int   prev = -1;
        logic owner_q[$];
        logic g, o;
        do_reset();
        a[0] = 5; b[0] = 5; c[0] = 4'd2;
        a[1] = 32'hF0; b[1] = 32'h0F; c[1] = 4'd5;
        rr[0] = 1; rr[1] = 1; v[0] = 1; v[1] = 1;
        for (int cyc = 0; cyc < 60 && ops < 8; cyc++) begin
            #1;
            if (rdy[0] || rdy[1]) begin
                g = ~exp_last;
                checks++; if ({rdy[1], rdy[0]} !== (g ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp_grant=%0d", cyc, {rdy[1], rdy[0]}, g); end
                owner_q.push_back(g);
                exp_last = g;
            end
            if (rspv[0] || rspv[1]) begin
                o = 1'b0;
                checks++;
                if (owner_q.size() == 0) begin failures++; $display("FAIL rr_unexpected_rsp cyc=%0d got=%b exp=none", cyc, {rspv[1], rspv[0]}); end
                else o = owner_q.pop_front();
                checks++; if ({rspv[1], rspv[0]} !== (o ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_route cyc=%0d got=%b owner=%0d", cyc, {rspv[1], rspv[0]}, o); end
                checks++;
                if (!o && (y !== 32'd0 || flags[0] !== 1'b1)) begin failures++; $display("FAIL rr_sub y=%h z=%b exp=0,1", y, flags[0]); end
                else if (o && y !== 32'hFF) begin failures++; $display("FAIL rr_or y=%h exp=000000ff", y); end
                if (prev >= 0) begin
                    checks++; if (cyc - prev != 3) begin failures++; $display("FAIL rr_spacing got=%0d exp=3", cyc - prev); end
                end
                prev = cyc;
                ops++;
                exp_cnt++;
            end
            @(negedge clk);
        end
        drive_idle();
        checks++; if (ops != 8) begin failures++; $display("FAIL rr_timeout ops=%0d exp=8", ops); end
        #1;
        checks++; if (cnt !== exp_cnt) begin failures++; $display("FAIL rr_count got=%h exp=%h", cnt, exp_cnt); end
    endtask

    task automatic test_backpressure();
        logic [31:0] ey0, ey1;
        logic [3:0]  ef0, ef1;
        logic        ee0, ee1;
        a[0] = $urandom; b[0] = $urandom; c[0] = 4'($urandom_range(0, 13));
        model(a[0], b[0], c[0], ey0, ef0, ee0);
        @(negedge clk);
        v[0] = 1; v[1] = 0;
        @(posedge clk);
        exp_last = 0;
        @(negedge clk);
        v[0] = 0; v[1] = 1; rr[0] = 0; rr[1] = 1;
        a[1] = $urandom; b[1] = $urandom; c[1] = 4'($urandom_range(0, 13));
        model(a[1], b[1], c[1], ey1, ef1, ee1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a[0] = $urandom; b[0] = $urandom; v[0] = 1'($urandom);
            #1;
            checks++; if ({rspv[1], rspv[0]} !== 2'b01) begin failures++; $display("FAIL bp_rspv i=%0d got=%b exp=01", i, {rspv[1], rspv[0]}); end
            checks++; if (y !== ey0 || flags !== ef0 || err !== ee0) begin failures++; $display("FAIL bp_hold i=%0d y=%h f=%b exp=%h,%b", i, y, flags, ey0, ef0); end
            checks++; if (rdy[1] !== 1'b0) begin failures++; $display("FAIL bp_ready1 i=%0d got=%b exp=0", i, rdy[1]); end
            checks++; if (cnt !== exp_cnt) begin failures++; $display("FAIL bp_count i=%0d got=%h exp=%h", i, cnt, exp_cnt); end
        end
        @(negedge clk);
        rr[0] = 1; v[0] = 0;
        #1;
        checks++; if (rdy[1] !== 1'b0) begin failures++; $display("FAIL bp_hs_ready1 got=%b exp=0", rdy[1]); end
        @(posedge clk);
        exp_cnt++;
        @(negedge clk);
        rr[0] = 0;
        #1;
        checks++; if (rdy[1] !== 1'b1) begin failures++; $display("FAIL bp_after_ready1 got=%b exp=1", rdy[1]); end
        @(posedge clk);
        exp_last = 1;
        @(negedge clk);
        v[1] = 0;
        @(negedge clk);
        #1;
        checks++; if ({rspv[1], rspv[0]} !== 2'b10 || y !== ey1 || flags !== ef1) begin failures++; $display("FAIL bp_op1 rspv=%b y=%h f=%b exp=10,%h,%b", {rspv[1], rspv[0]}, y, flags, ey1, ef1); end
        @(posedge clk);
        exp_cnt++;
        @(negedge clk);
        drive_idle();
        #1;
        checks++; if (cnt !== exp_cnt) begin failures++; $display("FAIL bp_count_end got=%h exp=%h", cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        a[0] = $urandom; b[0] = $urandom; c[0] = 4'd1;
        v[0] = 1;
        @(posedge clk);
        @(negedge clk);
        v[0] = 0; rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        checks++; if (busy !== 1'b0 || {rspv[1], rspv[0]} !== 2'b00) begin failures++; $display("FAIL rmid_exec busy=%b rspv=%b exp=0,00", busy, {rspv[1], rspv[0]}); end
        checks++; if (cnt !== exp_cnt || y !== 32'd0) begin failures++; $display("FAIL rmid_exec_state cnt=%h y=%h exp=%h,0", cnt, y, exp_cnt); end
        v[0] = 1;
        @(posedge clk);
        @(negedge clk);
        v[0] = 0;
        @(negedge clk);
        #1;
        checks++; if ({rspv[1], rspv[0]} !== 2'b01) begin failures++; $display("FAIL rmid_resp got=%b exp=01", {rspv[1], rspv[0]}); end
        rr[0] = 1; rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0; rr[0] = 0;
        #1;
        checks++; if (busy !== 1'b0 || {rspv[1], rspv[0]} !== 2'b00) begin failures++; $display("FAIL rmid_resp_idle busy=%b rspv=%b exp=0,00", busy, {rspv[1], rspv[0]}); end
        checks++; if (cnt !== exp_cnt) begin failures++; $display("FAIL rmid_count got=%h exp=%h", cnt, exp_cnt); end
        v[0] = 1; v[1] = 1;
        #1;
        checks++; if ({rdy[1], rdy[0]} !== 2'b01) begin failures++; $display("FAIL rmid_tie got=%b exp=01", {rdy[1], rdy[0]}); end
        drive_idle();
    endtask

    task automatic test_wrap();
        int          ops = 0;
        int          prev = -1;
        logic [31:0] exp_q[$];
        logic [31:0] ey, ex;
        logic [3:0]  ef;
        logic        ee;
        do_reset();
        force dut.r_done_count = 16'hFFF0;
        @(posedge clk);
        @(negedge clk);
        release dut.r_done_count;
        exp_cnt = 16'hFFF0;
        v[0] = 1; c[0] = 4'd1; rr[0] = 1; v[1] = 0;
        for (int cyc = 0; cyc < 200 && ops < 24; cyc++) begin
            a[0] = $urandom; b[0] = $urandom;
            #1;
            checks++; if (cnt !== exp_cnt) begin failures++; $display("FAIL wrap_count cyc=%0d got=%h exp=%h", cyc, cnt, exp_cnt); end
            if (rdy[0]) begin
                model(a[0], b[0], 4'd1, ey, ef, ee);
                exp_q.push_back(ey);
            end
            if (rspv[0]) begin
                ex = 32'hX;
                if (exp_q.size() != 0) ex = exp_q.pop_front();
                checks++; if (y !== ex) begin failures++; $display("FAIL wrap_y cyc=%0d got=%h exp=%h", cyc, y, ex); end
                if (prev >= 0) begin
                    checks++; if (cyc - prev != 3) begin failures++; $display("FAIL wrap_spacing got=%0d exp=3", cyc - prev); end
                end
                prev = cyc;
                ops++;
                exp_cnt++;
            end
            @(negedge clk);
        end
        drive_idle();
        checks++; if (ops != 24) begin failures++; $display("FAIL wrap_timeout ops=%0d exp=24", ops); end
        #1;
        checks++; if (cnt !== 16'h0008) begin failures++; $display("FAIL wrap_final got=%h exp=0008", cnt); end
    endtask

    initial begin
        rst = 1;
        drive_idle();
        a[0] = 0; b[0] = 0; c[0] = 0;
        a[1] = 0; b[1] = 0; c[1] = 0;
        exp_cnt = 0;
        exp_last = 1;
        test_reset();
        test_ops();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
